dvfs_transition_sequencer: RTL
==============================

// Module: dvfs_transition_sequencer
// PURPOSE
//  Downstream of the DVFS governor: takes requested freq/volt levels, drives the VRM and PLL in
//  safe order. Voltage is raised before frequency rises; frequency is lowered before voltage drops.
//  Stalls the core clock during PLL relock and reports the applied (current) levels.
// PARAMETERS
//  LVL_W          3     width of level codes (0..7)
//  RESET_LEVEL    2     applied freq/volt level after reset
//  SETTLE_CYCLES  16    hold-off after a completed transition before the next target is sampled
//  ACK_TIMEOUT    8192  max cycles to wait for vrm_ack/pll_lock (only with DVFS_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1      reference clock
//  rst            in   1      synchronous reset, active-high
//  tgt_freq_level in   LVL_W  requested frequency level from governor
//  tgt_volt_level in   LVL_W  requested voltage level from governor
//  vrm_req        out  1      voltage change request to regulator
//  vrm_level      out  LVL_W  voltage level presented to regulator
//  vrm_ack        in   1      regulator output settled at vrm_level
//  pll_req        out  1      PLL retune request
//  pll_sel        out  LVL_W  PLL frequency select
//  pll_lock       in   1      PLL locked at pll_sel
//  clk_stall      out  1      gate core clock (high while pll_req)
//  cur_freq_level out  LVL_W  applied frequency level
//  cur_volt_level out  LVL_W  applied voltage level
//  busy           out  1      sequencer not in IDLE
//  err            out  1      sticky timeout error (0 without DVFS_SEQ_TIMEOUT_EN)
//  err_clr        in   1      clears err, returns ERR->IDLE
// BEHAVIOUR
//  Reset: state IDLE; vrm_req=pll_req=clk_stall=busy=err=0; vrm_level=pll_sel=cur_*=RESET_LEVEL.
//  States: IDLE, V_UP, F_CHG, V_DOWN, SETTLE, ERR.
//  IDLE: when tgt_* != cur_*, latch tgt_* into internal t_f/t_v (one cycle), then:
//   t_v > cur_v -> V_UP; else t_f != cur_f -> F_CHG; else (t_v < cur_v only) -> V_DOWN.
//  V_UP: vrm_level=t_v, vrm_req=1 until vrm_ack sampled high; then cur_v<=t_v, vrm_req<=0;
//   -> F_CHG if t_f != cur_f else SETTLE.
//  F_CHG: pll_sel=t_f, pll_req=clk_stall=1 until pll_lock sampled high; then cur_f<=t_f, drop both;
//   -> V_DOWN if t_v < cur_v else SETTLE.
//  V_DOWN: as V_UP with t_v < cur_v; -> SETTLE.
//  SETTLE: count SETTLE_CYCLES cycles, -> IDLE. busy=1 in all states but IDLE.
//  Handshake: vrm_level/pll_sel stable whenever req high; req deasserts the cycle after ack/lock;
//   an ack/lock arriving while req low is ignored; only one of vrm_req/pll_req high at any time.
//  Targets changing mid-sequence are ignored; re-evaluated on return to IDLE (latest value wins).
//  cur_* update only on ack/lock, so they always reflect hardware-confirmed levels.
//  Jumps are taken in one step (e.g. 2->7); no intermediate levels.
//  rst mid-transition: immediate return to reset values; VRM/PLL re-driven to RESET_LEVEL.
// CONFIGURATION
//  DVFS_SEQ_TIMEOUT_EN defined: per-wait counter; ACK_TIMEOUT cycles without ack/lock -> ERR:
//   drop req/clk_stall, err=1, cur_* unchanged; ERR -> IDLE on err_clr. ack on the timeout
//   cycle wins (no error). Undefined: waits indefinitely, err tied 0, no counter logic.
// STRUCTURE
//  dvfs_pkg: LVL_W, RESET_LEVEL, state enum dvfs_seq_state_t, shared level typedef.
//  Sub-module dvfs_ack_timer: start/clear/expire counter reused for SETTLE and timeout waits.
// TESTING
//  Up: cur 2/2, tgt 5/5 -> vrm_req(level5) first; after ack, pll_req(sel5)+clk_stall; after lock cur=5/5.
//  Down: cur 5/5, tgt 3/3 -> pll_req(sel3) first; after lock, vrm_req(level3); cur=3/3, SETTLE 16 cycles.
//  Volt-only: tgt_v 4, tgt_f=cur_f=2 -> V_UP only, pll_req never asserts.
//  Mid-change: tgt 6/6 during V_UP -> completes current target, then sequences to 6/6 after SETTLE.
//  Timeout (macro on): withhold pll_lock 8192 cycles -> err=1, pll_req=0, cur_f unchanged; err_clr -> IDLE.
//  Reset during F_CHG -> next cycle pll_req=0, cur_*=2, vrm_level=pll_sel=2, busy=0.

Source files
------------

// File: rtl/dvfs_pkg.sv
// Shared types and constants for the DVFS transition sequencer.
// Defining DVFS_SEQ_TIMEOUT_EN widens the shared timer so it can also cover ACK_TIMEOUT.
package dvfs_pkg;

    localparam int LVL_W         = 3;
    localparam int RESET_LEVEL   = 2;
    localparam int SETTLE_CYCLES = 16;
    localparam int ACK_TIMEOUT   = 8192;

`ifdef DVFS_SEQ_TIMEOUT_EN
    localparam int TIMER_W = $clog2((ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES);
`else
    localparam int TIMER_W = $clog2(SETTLE_CYCLES);
`endif

    typedef logic [LVL_W-1:0] dvfs_level_t;

    localparam dvfs_level_t RESET_LVL = dvfs_level_t'(RESET_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_UP,
        ST_F_CHG,
        ST_V_DOWN,
        ST_SETTLE,
        ST_ERR
    } dvfs_seq_state_t;

endpackage

// File: rtl/dvfs_ack_timer.sv
// Cycle counter shared by the SETTLE hold-off and the handshake timeout waits.
// Expires on the cycle whose count equals i_last, so the wait lasts i_last+1 cycles.
module dvfs_ack_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    assign o_expired = i_run && (r_count == i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders VRM and PLL changes: raise voltage before frequency, lower frequency before voltage.
// Defining DVFS_SEQ_TIMEOUT_EN adds the handshake timeout and the sticky err output.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LVL_W-1:0] i_tgt_freq_level,
    input  logic [LVL_W-1:0] i_tgt_volt_level,
    output logic             o_vrm_req,
    output logic [LVL_W-1:0] o_vrm_level,
    input  logic             i_vrm_ack,
    output logic             o_pll_req,
    output logic [LVL_W-1:0] o_pll_sel,
    input  logic             i_pll_lock,
    output logic             o_clk_stall,
    output logic [LVL_W-1:0] o_cur_freq_level,
    output logic [LVL_W-1:0] o_cur_volt_level,
    output logic             o_busy,
    output logic             o_err,
    input  logic             i_err_clr
);

    dvfs_seq_state_t    r_state;
    dvfs_seq_state_t    w_next_state;
    dvfs_level_t        r_t_f;
    dvfs_level_t        r_t_v;
    dvfs_level_t        r_cur_f;
    dvfs_level_t        r_cur_v;
    dvfs_level_t        r_vrm_level;
    dvfs_level_t        r_pll_sel;
    dvfs_level_t        w_sel_f;
    dvfs_level_t        w_sel_v;
    logic               w_timer_run;
    logic               w_timer_clear;
    logic               w_timer_expired;
    logic [TIMER_W-1:0] w_timer_last;

    // In IDLE the targets are still on the inputs; afterwards only the latched copy counts.
    assign w_sel_f       = (r_state == ST_IDLE) ? i_tgt_freq_level : r_t_f;
    assign w_sel_v       = (r_state == ST_IDLE) ? i_tgt_volt_level : r_t_v;
    assign w_timer_clear = (w_next_state != r_state);

    dvfs_ack_timer #(.CNT_W(TIMER_W)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_timer_clear),
        .i_run     (w_timer_run),
        .i_last    (w_timer_last),
        .o_expired (w_timer_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_timer_run  = 1'b0;
        w_timer_last = TIMER_W'(SETTLE_CYCLES - 1);
        case (r_state)
            ST_IDLE: begin
                if (w_sel_v > r_cur_v)      w_next_state = ST_V_UP;
                else if (w_sel_f != r_cur_f) w_next_state = ST_F_CHG;
                else if (w_sel_v < r_cur_v)  w_next_state = ST_V_DOWN;
            end
            ST_V_UP, ST_V_DOWN: begin
`ifdef DVFS_SEQ_TIMEOUT_EN
                w_timer_run  = 1'b1;
                w_timer_last = TIMER_W'(ACK_TIMEOUT - 1);
`endif
                if (i_vrm_ack) begin
                    if (r_state == ST_V_UP && r_t_f != r_cur_f) w_next_state = ST_F_CHG;
                    else                                         w_next_state = ST_SETTLE;
                end else if (w_timer_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_F_CHG: begin
`ifdef DVFS_SEQ_TIMEOUT_EN
                w_timer_run  = 1'b1;
                w_timer_last = TIMER_W'(ACK_TIMEOUT - 1);
`endif
                if (i_pll_lock) begin
                    if (r_t_v < r_cur_v) w_next_state = ST_V_DOWN;
                    else                 w_next_state = ST_SETTLE;
                end else if (w_timer_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_SETTLE: begin
                w_timer_run = 1'b1;
                if (w_timer_expired) w_next_state = ST_IDLE;
            end
            ST_ERR: begin
                if (i_err_clr) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request levels load only on entry to a wait state, so they never move while a req is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_t_f       <= RESET_LVL;
            r_t_v       <= RESET_LVL;
            r_cur_f     <= RESET_LVL;
            r_cur_v     <= RESET_LVL;
            r_vrm_level <= RESET_LVL;
            r_pll_sel   <= RESET_LVL;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_next_state != ST_IDLE) begin
                r_t_f <= i_tgt_freq_level;
                r_t_v <= i_tgt_volt_level;
            end
            if ((w_next_state == ST_V_UP || w_next_state == ST_V_DOWN) && w_next_state != r_state)
                r_vrm_level <= w_sel_v;
            if (w_next_state == ST_F_CHG && r_state != ST_F_CHG)
                r_pll_sel <= w_sel_f;
            if ((r_state == ST_V_UP || r_state == ST_V_DOWN) && i_vrm_ack)
                r_cur_v <= r_t_v;
            if (r_state == ST_F_CHG && i_pll_lock)
                r_cur_f <= r_t_f;
        end
    end

    assign o_vrm_req        = (r_state == ST_V_UP) || (r_state == ST_V_DOWN);
    assign o_pll_req        = (r_state == ST_F_CHG);
    assign o_clk_stall      = (r_state == ST_F_CHG);
    assign o_vrm_level      = r_vrm_level;
    assign o_pll_sel        = r_pll_sel;
    assign o_cur_freq_level = r_cur_f;
    assign o_cur_volt_level = r_cur_v;
    assign o_busy           = (r_state != ST_IDLE);
`ifdef DVFS_SEQ_TIMEOUT_EN
    assign o_err            = (r_state == ST_ERR);
`else
    assign o_err            = 1'b0;
`endif

endmodule
